sram_phy_arbiter: RTL

SRAM_PHY_ARBITER -- requirements
Module: sram_phy_arbiter

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/rr_arb2.sv | 17 +
 rtl/sram_phy_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and FSM encoding for the two-requester SRAM controller.
package sram_ctrl_pkg;

    localparam int NUM_REQ   = 2;
    localparam int READ_LAT  = 3;   // accept cycle -> rsp_valid cycle
    localparam int WRITE_LAT = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester named by ptr has priority.
module rr_arb2 (
    input  logic       ptr,
    input  logic [1:0] valid,
    output logic [1:0] gnt
);

    // Priority requester wins when valid, otherwise fall back to the other one.
    always_comb begin
        gnt = 2'b00;
        if (valid[ptr])
            gnt[ptr] = 1'b1;
        else if (valid[~ptr])
            gnt[~ptr] = 1'b1;
    end

endmodule

// File: rtl/sram_phy_arbiter.sv
// Arbitrates two requesters onto one asynchronous SRAM PHY. Each access
// takes four cycles (accept + three PHY cycles); the PHY address, byte
// enables and write data are registered at grant so they are stable for
// the whole time chip-enable is low.
module sram_phy_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int W_ADDR = 18,
    parameter int W_DATA = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*W_ADDR-1:0]   req_addr,
    input  logic [NUM_REQ*W_DATA-1:0]   req_wdata,
    input  logic [NUM_REQ*W_DATA/8-1:0] req_byte_n,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [W_DATA-1:0]           rsp_rdata,
    output logic [W_ADDR-1:0]           phy_addr,
    output logic [W_DATA-1:0]           phy_dq_out,
    output logic [W_DATA-1:0]           phy_dq_oe,
    input  logic [W_DATA-1:0]           phy_dq_in,
    output logic                        phy_ce_n,
    output logic                        phy_we_n,
    output logic                        phy_oe_n,
    output logic [W_DATA/8-1:0]         phy_byte_n
);

    localparam int W_BE = W_DATA / 8;

    state_t              state, state_nxt;
    logic                ptr;
    logic [1:0]          gnt;
    logic                gnt_idx;
    logic                grant_now;
    logic [1:0]          owner;      // one-hot requester owning the access
    logic [W_BE-1:0]     byte_n_q;

    logic                sel_write;
    logic [W_ADDR-1:0]   sel_addr;
    logic [W_DATA-1:0]   sel_wdata;
    logic [W_BE-1:0]     sel_byte_n;

    rr_arb2 u_arb (
        .ptr   (ptr),
        .valid (req_valid),
        .gnt   (gnt)
    );

    assign gnt_idx   = gnt[1];
    assign grant_now = (state == IDLE) && (gnt != 2'b00) && !rst;

    // Select the granted requester's request fields.
    always_comb begin
        sel_write  = gnt_idx ? req_write[1] : req_write[0];
        sel_addr   = gnt_idx ? req_addr[2*W_ADDR-1:W_ADDR] : req_addr[W_ADDR-1:0];
        sel_wdata  = gnt_idx ? req_wdata[2*W_DATA-1:W_DATA] : req_wdata[W_DATA-1:0];
        sel_byte_n = gnt_idx ? req_byte_n[2*W_BE-1:W_BE] : req_byte_n[W_BE-1:0];
    end

    // Next-state and accept strobe; ready is only ever raised in IDLE.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_now) begin
                    req_ready = gnt;
                    state_nxt = sel_write ? WR_SETUP : RD0;
                end
            end
            RD0:      state_nxt = RD1;
            RD1:      state_nxt = RD_DONE;
            RD_DONE:  state_nxt = IDLE;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register and round-robin pointer (points at the loser after a grant).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            owner <= 2'b00;
        end else begin
            state <= state_nxt;
            if (grant_now) begin
                ptr   <= ~gnt_idx;
                owner <= gnt;
            end
        end
    end

    // Request latch feeding the PHY, plus read-data capture at the end of RD1.
    always_ff @(posedge clk) begin
        if (rst) begin
            phy_addr   <= '0;
            phy_dq_out <= '0;
            byte_n_q   <= '1;
            rsp_rdata  <= '0;
        end else begin
            if (grant_now) begin
                phy_addr   <= sel_addr;
                phy_dq_out <= sel_wdata;
                byte_n_q   <= sel_byte_n;
            end
            if (state == RD1)
                rsp_rdata <= phy_dq_in;
        end
    end

    // PHY strobes and completion pulse decoded from state; idle by default.
    always_comb begin
        phy_ce_n   = 1'b1;
        phy_oe_n   = 1'b1;
        phy_we_n   = 1'b1;
        phy_dq_oe  = '0;
        phy_byte_n = '1;
        rsp_valid  = '0;
        case (state)
            RD0, RD1: begin
                phy_ce_n   = 1'b0;
                phy_oe_n   = 1'b0;
                phy_byte_n = byte_n_q;
            end
            RD_DONE: rsp_valid = owner;
            WR_SETUP: begin
                phy_ce_n   = 1'b0;
                phy_dq_oe  = '1;
                phy_byte_n = byte_n_q;
            end
            WR_PULSE: begin
                phy_ce_n   = 1'b0;
                phy_we_n   = 1'b0;
                phy_dq_oe  = '1;
                phy_byte_n = byte_n_q;
            end
            WR_HOLD: begin
                phy_ce_n   = 1'b0;
                phy_dq_oe  = '1;
                phy_byte_n = byte_n_q;
                rsp_valid  = owner;
            end
            default: ;
        endcase
    end

endmodule
